// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int unsigned depth(input int unsigned reg_width);
    return 32'd1 << reg_width;
  endfunction

  // Low bit of lane `lane` in a flat vector of `width`-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeros through the array after reset or on request,
// then holds RUN; also flags writes that arrive while the sweep is active.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned NUM_WR    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  input  logic [NUM_WR-1:0]    wr_en,
  output logic                 ready,
  output logic                 wr_drop,
  output logic                 clr_we,
  output logic [REG_WIDTH-1:0] clr_idx
);

  localparam logic [REG_WIDTH-1:0] LAST_IDX = '1;

  state_t               state;
  state_t               state_nxt;
  logic [REG_WIDTH-1:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      wr_drop <= (state == ST_CLEAR) && (|wr_en);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        // Reset edges must not touch the array.
        clr_we = reset;
        if (clr_idx == LAST_IDX) begin
          state_nxt = ST_RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = clr_idx + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign ready = (state == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: reset-free storage, priority write ports,
// combinational reads with optional same-cycle write bypass, entry 0 reads zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_req,
  output logic                         ready,
  input  logic [NUM_RD*REG_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*REG_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic                         wr_drop
);

  localparam int unsigned DEPTH = depth(REG_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [REG_WIDTH-1:0]  clr_idx;
  logic                  wr_ok;

  regfile_clear_seq #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_WR    (NUM_WR)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .wr_en   (wr_en),
    .ready   (ready),
    .wr_drop (wr_drop),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_ok = ready && reset;

  // Later ports overwrite earlier ones, giving highest-index priority.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[lane_lo(w, REG_WIDTH) +: REG_WIDTH] != '0))
          mem[wr_addr[lane_lo(w, REG_WIDTH) +: REG_WIDTH]] <= wr_data[lane_lo(w, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = rd_addr[lane_lo(p, REG_WIDTH) +: REG_WIDTH];

    always_comb begin
      data = '0;
      if (ready && (addr != '0)) begin
        data = mem[addr];
        if (BYPASS != 0) begin
          for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[lane_lo(w, REG_WIDTH) +: REG_WIDTH] == addr))
              data = wr_data[lane_lo(w, DATA_WIDTH) +: DATA_WIDTH];
          end
        end
      end
    end

    assign rd_data[lane_lo(p, DATA_WIDTH) +: DATA_WIDTH] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (2 write ports with bypass,
// 1 write port without bypass) sharing clock, reset and clear request.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clr_req;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_ready;
  logic        a_drop;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_ready;
  logic        b_drop;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb[$];

  regfile_mp #(
    .DATA_WIDTH (32),
    .REG_WIDTH  (5),
    .NUM_RD     (2),
    .NUM_WR     (2),
    .BYPASS     (1)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .ready   (a_ready),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data),
    .wr_en   (a_wr_en),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .wr_drop (a_drop)
  );

  regfile_mp #(
    .DATA_WIDTH (32),
    .REG_WIDTH  (5),
    .NUM_RD     (2),
    .NUM_WR     (1),
    .BYPASS     (0)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .ready   (b_ready),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .wr_en   (b_wr_en),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .wr_drop (b_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation exceeded time limit");
  end

  initial begin
    int n;

    reset     = 1'b0;
    clr_req   = 1'b0;
    a_rd_addr = '0;
    a_wr_en   = '0;
    a_wr_addr = '0;
    a_wr_data = '0;
    b_rd_addr = '0;
    b_wr_en   = '0;
    b_wr_addr = '0;
    b_wr_data = '0;

    // Reset low for three edges, then a full sweep of 32 edges.
    repeat (3) tick();
    check("reset_ready_a", 64'(a_ready), 64'd0);
    check("reset_drop_a", 64'(a_drop), 64'd0);
    check("reset_ready_b", 64'(b_ready), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      b_rd_addr = {5'(i), 5'(31 - i)};
      sample();
      check("sweep_ready_a", 64'(a_ready), 64'd0);
      check("sweep_ready_b", 64'(b_ready), 64'd0);
      check("sweep_rd_a", a_rd_data, 64'd0);
      check("sweep_rd_b", b_rd_data, 64'd0);
      tick();
    end
    check("sweep_done_a", 64'(a_ready), 64'd1);
    check("sweep_done_b", 64'(b_ready), 64'd1);

    // Basic write then read on both ports.
    a_wr_en   = 2'b01;
    a_wr_addr = {5'd0, 5'd5};
    a_wr_data = {32'd0, 32'hDEADBEEF};
    tick();
    a_wr_en   = '0;
    a_rd_addr = {5'd5, 5'd5};
    sb_push("x5_p0", 64'hDEADBEEF);
    sb_push("x5_p1", 64'hDEADBEEF);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    sb_check(64'(a_rd_data[63:32]));
    check("run_drop_a", 64'(a_drop), 64'd0);
    tick();

    // Writes to entry 0 are ignored and never bypassed.
    a_wr_en   = 2'b01;
    a_wr_addr = {5'd0, 5'd0};
    a_wr_data = {32'd0, 32'h00001234};
    a_rd_addr = {5'd5, 5'd0};
    sb_push("x0_same", 64'd0);
    sb_push("x5_keep", 64'hDEADBEEF);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    sb_check(64'(a_rd_data[63:32]));
    tick();
    a_wr_en = '0;
    sb_push("x0_after", 64'd0);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    check("x0_drop", 64'(a_drop), 64'd0);
    tick();

    // Both write ports hit x7: port 1 wins, also on the bypass path.
    a_wr_en   = 2'b11;
    a_wr_addr = {5'd7, 5'd7};
    a_wr_data = {32'h00000022, 32'h00000011};
    a_rd_addr = {5'd5, 5'd7};
    sb_push("x7_bypass", 64'h22);
    sb_push("x5_other", 64'hDEADBEEF);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    sb_check(64'(a_rd_data[63:32]));
    tick();
    a_wr_en   = '0;
    a_rd_addr = {5'd7, 5'd7};
    sb_push("x7_p0", 64'h22);
    sb_push("x7_p1", 64'h22);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    sb_check(64'(a_rd_data[63:32]));
    tick();

    // No bypass: same-cycle read returns the old value.
    b_wr_en   = 1'b1;
    b_wr_addr = 5'd3;
    b_wr_data = 32'hA;
    tick();
    b_wr_data = 32'hB;
    b_rd_addr = {5'd3, 5'd3};
    sb_push("x3_old_p0", 64'hA);
    sb_push("x3_old_p1", 64'hA);
    sample();
    sb_check(64'(b_rd_data[31:0]));
    sb_check(64'(b_rd_data[63:32]));
    tick();
    b_wr_en = 1'b0;
    sb_push("x3_new", 64'hB);
    sample();
    sb_check(64'(b_rd_data[31:0]));
    tick();

    // Clear request with a write in the same cycle, then a dropped write.
    clr_req   = 1'b1;
    a_wr_en   = 2'b01;
    a_wr_addr = {5'd0, 5'd9};
    a_wr_data = {32'd0, 32'h55};
    a_rd_addr = {5'd0, 5'd9};
    sb_push("x9_bypass", 64'h55);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    check("clrreq_ready", 64'(a_ready), 64'd1);
    tick();
    clr_req   = 1'b0;
    a_wr_addr = {5'd0, 5'd12};
    a_wr_data = {32'd0, 32'h77};
    a_rd_addr = {5'd0, 5'd12};
    sb_push("clear_rd", 64'd0);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    check("clear_ready", 64'(a_ready), 64'd0);
    tick();
    a_wr_en = '0;
    clr_req = 1'b1;
    sample();
    check("drop_pulse", 64'(a_drop), 64'd1);
    check("drop_b_quiet", 64'(b_drop), 64'd0);
    tick();
    clr_req = 1'b0;
    sample();
    check("drop_end", 64'(a_drop), 64'd0);
    tick();
    n = 3;
    while (!a_ready && n < 40) begin
      tick();
      n++;
    end
    check("clear_len", 64'(n), 64'd32);
    check("clear_ready_b", 64'(b_ready), 64'd1);
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      sb_push("zero_p0", 64'd0);
      sb_push("zero_p1", 64'd0);
      sample();
      sb_check(64'(a_rd_data[31:0]));
      sb_check(64'(a_rd_data[63:32]));
      tick();
    end

    // Reset mid-sweep at clr_idx 10 restarts; clr_req during the sweep is ignored.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    a_rd_addr = {5'd7, 5'd5};
    sample();
    check("midrst_ready", 64'(a_ready), 64'd0);
    check("midrst_drop", 64'(a_drop), 64'd0);
    check("midrst_rd", a_rd_data, 64'd0);
    reset   = 1'b1;
    clr_req = 1'b1;
    n = 0;
    tick();
    n++;
    clr_req = 1'b0;
    while (!a_ready && n < 40) begin
      tick();
      n++;
    end
    check("restart_len", 64'(n), 64'd32);
    check("restart_ready_b", 64'(b_ready), 64'd1);
    a_rd_addr = {5'd7, 5'd5};
    sb_push("post_x5", 64'd0);
    sb_push("post_x7", 64'd0);
    sample();
    sb_check(64'(a_rd_data[31:0]));
    sb_check(64'(a_rd_data[63:32]));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
